// File: rtl/store_buffer_fwd_pkg.sv
// Shared types and helpers for the store buffer: entry layout, access-size encodings, lane expansion.
// No logic of its own. No backpressure.
// Imported by the store buffer top and by the forwarding merge.
package calvera_sb_pkg;

    typedef enum logic [1:0] {
        ST_B = 2'b00,
        ST_H = 2'b01,
        ST_W = 2'b10
    } st_op_e;

    typedef struct packed {
        logic [5:0]  rob;
        logic [29:0] waddr;
        logic [3:0]  bm;
        logic [31:0] data;
    } sb_entry_t;

    // Encoding 11 is illegal and is handled as a full word.
    function automatic logic [3:0] size_to_bm(input logic [1:0] op, input logic [1:0] a);
        logic [3:0] base;
        case (op)
            ST_B:    base = 4'b0001;
            ST_H:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << a;
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] op, input logic [31:0] d);
        logic [31:0] r;
        case (op)
            ST_B:    r = {4{d[7:0]}};
            ST_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load match across all entries with a per-byte youngest-wins merge.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; it is a lookup and accepts a query every cycle.
module sb_fwd_merge #(
    parameter int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]        vld_i,
    input  logic [DEPTH-1:0][29:0]  waddr_i,
    input  logic [DEPTH-1:0][3:0]   bm_i,
    input  logic [DEPTH-1:0][31:0]  data_i,
    input  logic [IDX_W-1:0]        head_i,
    input  logic [29:0]             ld_waddr_i,
    input  logic [3:0]              ld_bm_i,
    output logic [31:0]             data_o,
    output logic [3:0]              bm_o,
    output logic                    res_valid_o,
    output logic                    io_hit_o
);

    logic [IDX_W-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overwrites the bytes it supplies.
    always_comb begin
        data_o      = '0;
        bm_o        = '0;
        res_valid_o = 1'b0;
        io_hit_o    = 1'b0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + IDX_W'(k);
            if (vld_i[idx] && (waddr_i[idx] == ld_waddr_i) && (|(bm_i[idx] & ld_bm_i))) begin
                res_valid_o = 1'b1;
                if (waddr_i[idx][29]) begin
                    io_hit_o = 1'b1;
                end
                for (int b = 0; b < 4; b++) begin
                    if (bm_i[idx][b] && ld_bm_i[b]) begin
                        data_o[8*b +: 8] = data_i[idx][8*b +: 8];
                        bm_o[b]          = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer_fwd.sv
// In-order store buffer: holds stores until commit, drains them to memory, forwards to loads (STORE_FWD_EN).
// Latency: lookup is combinational; an enqueued store is visible to lookups the cycle after enqueue.
// Backpressure: st_busy_o (registered) refuses enqueue when full; the drain holds its payload until mem_ack_i.
module store_buffer_fwd
    import calvera_sb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,
    input  logic        flush_i,
    input  logic        st_vld_i,
    input  logic [5:0]  st_rob_i,
    input  logic [1:0]  st_op_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    output logic        st_busy_o,
    input  logic        commit_vld_i,
    input  logic [5:0]  commit_rob_i,
    input  logic [31:0] ld_addr_i,
    input  logic [1:0]  ld_op_i,
    output logic [31:0] conflict_data_o,
    output logic [3:0]  conflict_bm_o,
    output logic        conflict_resolvable_o,
    output logic        conflict_res_valid_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_bm_o,
    input  logic        mem_ack_i,
    output logic        store_buf_emp_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d, count;
    logic             st_busy_q, st_busy_d;
    logic             enq, deq, cmt_ok, tag_ok;
    sb_entry_t        ent_q [DEPTH];
    sb_entry_t        head_ent;

    logic [DEPTH-1:0]       ent_vld;
    logic [DEPTH-1:0][29:0] ent_waddr;
    logic [DEPTH-1:0][3:0]  ent_bm;
    logic [DEPTH-1:0][31:0] ent_data;
    logic [IDX_W-1:0]       age;
    logic [3:0]             ld_bm;
    logic [31:0]            fwd_data;
    logic [3:0]             fwd_bm;
    logic                   fwd_hit, fwd_io;

    always_comb begin
        count     = tail_q - head_q;
        head_ent  = ent_q[head_q[IDX_W-1:0]];
        tag_ok    = (commit_rob_i == ent_q[cmt_q[IDX_W-1:0]].rob);
        cmt_ok    = commit_vld_i && (cmt_q != tail_q) && tag_ok;
        deq       = (head_q != cmt_q) && mem_ack_i;
        enq       = st_vld_i && !st_busy_q && !flush_i;
        head_d    = head_q + PTR_W'(deq);
        cmt_d     = cmt_q + PTR_W'(cmt_ok);
        tail_d    = flush_i ? cmt_d : (tail_q + PTR_W'(enq));
        // Full only when indices meet with opposite wrap bits.
        st_busy_d = (tail_d[IDX_W-1:0] == head_d[IDX_W-1:0]) &&
                    (tail_d[PTR_W-1] != head_d[PTR_W-1]);
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            head_q    <= '0;
            cmt_q     <= '0;
            tail_q    <= '0;
            st_busy_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            cmt_q     <= cmt_d;
            tail_q    <= tail_d;
            st_busy_q <= st_busy_d;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (enq) begin
            ent_q[tail_q[IDX_W-1:0]] <= '{rob:   st_rob_i,
                                          waddr: st_addr_i[31:2],
                                          bm:    size_to_bm(st_op_i, st_addr_i[1:0]),
                                          data:  lane_data(st_op_i, st_data_i)};
        end
    end

    // The ROB must commit stores strictly in order; a tag mismatch is a pipeline bug.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_i && commit_vld_i && (cmt_q != tail_q)) begin
            assert (tag_ok);
        end
    end

    always_comb begin
        ent_vld   = '0;
        ent_waddr = '0;
        ent_bm    = '0;
        ent_data  = '0;
        age       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age          = IDX_W'(i) - head_q[IDX_W-1:0];
            ent_vld[i]   = ({1'b0, age} < count);
            ent_waddr[i] = ent_q[i].waddr;
            ent_bm[i]    = ent_q[i].bm;
            ent_data[i]  = ent_q[i].data;
        end
    end

    assign ld_bm = size_to_bm(ld_op_i, ld_addr_i[1:0]);

    sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd_merge (
        .vld_i       (ent_vld),
        .waddr_i     (ent_waddr),
        .bm_i        (ent_bm),
        .data_i      (ent_data),
        .head_i      (head_q[IDX_W-1:0]),
        .ld_waddr_i  (ld_addr_i[31:2]),
        .ld_bm_i     (ld_bm),
        .data_o      (fwd_data),
        .bm_o        (fwd_bm),
        .res_valid_o (fwd_hit),
        .io_hit_o    (fwd_io)
    );

    assign conflict_res_valid_o = fwd_hit;

`ifdef STORE_FWD_EN
    assign conflict_data_o       = fwd_data;
    assign conflict_bm_o         = fwd_bm;
    assign conflict_resolvable_o = fwd_hit && !fwd_io;
`else
    // Without forwarding every overlapping load misses and waits for the buffer to empty.
    logic unused_fwd;
    assign unused_fwd            = ^{fwd_data, fwd_bm, fwd_io};
    assign conflict_data_o       = '0;
    assign conflict_bm_o         = '0;
    assign conflict_resolvable_o = 1'b0;
`endif

    assign st_busy_o       = st_busy_q;
    assign mem_req_o       = (head_q != cmt_q);
    assign mem_addr_o      = {head_ent.waddr, 2'b00};
    assign mem_data_o      = head_ent.data;
    assign mem_bm_o        = head_ent.bm;
    assign store_buf_emp_o = (head_q == tail_q);

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd; expectations follow STORE_FWD_EN as seen by this file.
module tb_store_buffer_fwd;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        st_vld_i = 1'b0;
    logic [5:0]  st_rob_i = '0;
    logic [1:0]  st_op_i = '0;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        st_busy_o;
    logic        commit_vld_i = 1'b0;
    logic [5:0]  commit_rob_i = '0;
    logic [31:0] ld_addr_i = '0;
    logic [1:0]  ld_op_i = '0;
    logic [31:0] conflict_data_o;
    logic [3:0]  conflict_bm_o;
    logic        conflict_resolvable_o;
    logic        conflict_res_valid_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_bm_o;
    logic        mem_ack_i = 1'b0;
    logic        store_buf_emp_o;

    int checks = 0;
    int errors = 0;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    store_buffer_fwd #(.DEPTH(8)) dut (
        .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush_i),
        .st_vld_i(st_vld_i), .st_rob_i(st_rob_i), .st_op_i(st_op_i),
        .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_busy_o(st_busy_o),
        .commit_vld_i(commit_vld_i), .commit_rob_i(commit_rob_i),
        .ld_addr_i(ld_addr_i), .ld_op_i(ld_op_i),
        .conflict_data_o(conflict_data_o), .conflict_bm_o(conflict_bm_o),
        .conflict_resolvable_o(conflict_resolvable_o), .conflict_res_valid_o(conflict_res_valid_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_bm_o(mem_bm_o), .mem_ack_i(mem_ack_i), .store_buf_emp_o(store_buf_emp_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_st(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [5:0] rob);
        st_vld_i = 1'b1; st_op_i = op; st_addr_i = a; st_data_i = d; st_rob_i = rob;
        tick();
        st_vld_i = 1'b0;
    endtask

    task automatic do_commit(input logic [5:0] rob);
        commit_vld_i = 1'b1; commit_rob_i = rob;
        tick();
        commit_vld_i = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] op, input logic [31:0] a);
        ld_op_i = op; ld_addr_i = a;
        #1;
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        mem_ack_i = 1'b1;
        while (!store_buf_emp_o && n < 20) begin
            tick();
            n++;
        end
        mem_ack_i = 1'b0;
        checks++; if (store_buf_emp_o !== 1'b1) begin errors++; $display("FAIL drain_timeout emp=%b exp 1", store_buf_emp_o); end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        lookup(2'b10, 32'h0);
        checks++; if (st_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", st_busy_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req_o); end
        checks++; if (store_buf_emp_o !== 1'b1) begin errors++; $display("FAIL rst_emp got %b exp 1", store_buf_emp_o); end
        checks++; if (conflict_res_valid_o !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", conflict_res_valid_o); end
        checks++; if (conflict_resolvable_o !== 1'b0) begin errors++; $display("FAIL rst_resolvable got %b exp 0", conflict_resolvable_o); end
        checks++; if (conflict_bm_o !== 4'h0) begin errors++; $display("FAIL rst_bm got %h exp 0", conflict_bm_o); end
    endtask

    task automatic test_word_fwd();
        do_st(2'b10, 32'h1000, 32'hDEADBEEF, 6'd1);
        lookup(2'b10, 32'h1000);
        checks++; if (conflict_res_valid_o !== 1'b1) begin errors++; $display("FAIL t1_res_valid got %b exp 1", conflict_res_valid_o); end
        checks++; if (conflict_resolvable_o !== FWD) begin errors++; $display("FAIL t1_resolvable got %b exp %b", conflict_resolvable_o, FWD); end
        checks++; if (conflict_bm_o !== (FWD ? 4'hF : 4'h0)) begin errors++; $display("FAIL t1_bm got %h exp %h", conflict_bm_o, FWD ? 4'hF : 4'h0); end
        checks++; if (conflict_data_o !== (FWD ? 32'hDEADBEEF : 32'h0)) begin errors++; $display("FAIL t1_data got %h exp %h", conflict_data_o, FWD ? 32'hDEADBEEF : 32'h0); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t1_mem_req got %b exp 0", mem_req_o); end
        lookup(2'b10, 32'h1004);
        checks++; if (conflict_res_valid_o !== 1'b0) begin errors++; $display("FAIL t1_miss_res_valid got %b exp 0", conflict_res_valid_o); end
        do_commit(6'd1);
        drain_all();
    endtask

    task automatic test_byte_merge_drain();
        do_st(2'b00, 32'h1001, 32'h000000AA, 6'd2);
        do_st(2'b00, 32'h1001, 32'h000000BB, 6'd3);
        lookup(2'b01, 32'h1000);
        checks++; if (conflict_res_valid_o !== 1'b1) begin errors++; $display("FAIL t2_res_valid got %b exp 1", conflict_res_valid_o); end
        checks++; if (conflict_bm_o !== (FWD ? 4'b0010 : 4'h0)) begin errors++; $display("FAIL t2_bm got %h exp %h", conflict_bm_o, FWD ? 4'b0010 : 4'h0); end
        checks++; if (conflict_data_o !== (FWD ? 32'h0000BB00 : 32'h0)) begin errors++; $display("FAIL t2_data got %h exp %h", conflict_data_o, FWD ? 32'h0000BB00 : 32'h0); end
        do_commit(6'd2);
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t2_req got %b exp 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h1000) begin errors++; $display("FAIL t2_addr got %h exp 1000", mem_addr_o); end
        checks++; if (mem_bm_o !== 4'b0010) begin errors++; $display("FAIL t2_mbm got %h exp 2", mem_bm_o); end
        checks++; if (mem_data_o !== 32'hAAAAAAAA) begin errors++; $display("FAIL t2_mdata0 got %h exp aaaaaaaa", mem_data_o); end
        commit_vld_i = 1'b1; commit_rob_i = 6'd3; mem_ack_i = 1'b1;
        tick();
        commit_vld_i = 1'b0;
        checks++; if (mem_data_o !== 32'hBBBBBBBB) begin errors++; $display("FAIL t2_mdata1 got %h exp bbbbbbbb", mem_data_o); end
        checks++; if (store_buf_emp_o !== 1'b0) begin errors++; $display("FAIL t2_emp_mid got %b exp 0", store_buf_emp_o); end
        tick();
        mem_ack_i = 1'b0;
        checks++; if (store_buf_emp_o !== 1'b1) begin errors++; $display("FAIL t2_emp got %b exp 1", store_buf_emp_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_req_end got %b exp 0", mem_req_o); end
    endtask

    task automatic test_full_wrap();
        for (int k = 0; k < 8; k++) do_st(2'b10, 32'h2000 + 32'(4*k), 32'h11110000 + 32'(k), 6'(10 + k));
        checks++; if (st_busy_o !== 1'b1) begin errors++; $display("FAIL t3_busy_full got %b exp 1", st_busy_o); end
        do_st(2'b10, 32'h3000, 32'h99999999, 6'd30);
        lookup(2'b10, 32'h3000);
        checks++; if (conflict_res_valid_o !== 1'b0) begin errors++; $display("FAIL t3_refused got %b exp 0", conflict_res_valid_o); end
        for (int k = 0; k < 3; k++) do_commit(6'(10 + k));
        mem_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        mem_ack_i = 1'b0;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t3_req got %b exp 0", mem_req_o); end
        checks++; if (st_busy_o !== 1'b0) begin errors++; $display("FAIL t3_busy_drained got %b exp 0", st_busy_o); end
        do_st(2'b10, 32'h200C, 32'hCAFEF00D, 6'd18);
        do_st(2'b00, 32'h200E, 32'h00000077, 6'd19);
        do_st(2'b01, 32'h2014, 32'h00001234, 6'd20);
        checks++; if (st_busy_o !== 1'b1) begin errors++; $display("FAIL t3_busy_wrap got %b exp 1", st_busy_o); end
        lookup(2'b10, 32'h200C);
        checks++; if (conflict_res_valid_o !== 1'b1) begin errors++; $display("FAIL t3_res_valid got %b exp 1", conflict_res_valid_o); end
        checks++; if (conflict_data_o !== (FWD ? 32'hCA77F00D : 32'h0)) begin errors++; $display("FAIL t3_young_data got %h exp %h", conflict_data_o, FWD ? 32'hCA77F00D : 32'h0); end
        lookup(2'b01, 32'h2016);
        checks++; if (conflict_data_o !== (FWD ? 32'h11110000 : 32'h0)) begin errors++; $display("FAIL t3_upper_data got %h exp %h", conflict_data_o, FWD ? 32'h11110000 : 32'h0); end
        checks++; if (conflict_bm_o !== (FWD ? 4'b1100 : 4'h0)) begin errors++; $display("FAIL t3_upper_bm got %h exp %h", conflict_bm_o, FWD ? 4'b1100 : 4'h0); end
        lookup(2'b01, 32'h2014);
        checks++; if (conflict_data_o !== (FWD ? 32'h00001234 : 32'h0)) begin errors++; $display("FAIL t3_lower_data got %h exp %h", conflict_data_o, FWD ? 32'h00001234 : 32'h0); end
        for (int k = 13; k <= 20; k++) do_commit(6'(k));
        drain_all();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) do_st(2'b10, 32'h4000 + 32'(4*k), 32'h40000000 + 32'(k), 6'(30 + k));
        do_commit(6'd30);
        do_commit(6'd31);
        flush_i = 1'b1;
        do_st(2'b10, 32'h5000, 32'h55555555, 6'd34);
        flush_i = 1'b0;
        lookup(2'b10, 32'h4008);
        checks++; if (conflict_res_valid_o !== 1'b0) begin errors++; $display("FAIL t4_flushed got %b exp 0", conflict_res_valid_o); end
        lookup(2'b10, 32'h5000);
        checks++; if (conflict_res_valid_o !== 1'b0) begin errors++; $display("FAIL t4_dropped got %b exp 0", conflict_res_valid_o); end
        lookup(2'b10, 32'h4004);
        checks++; if (conflict_res_valid_o !== 1'b1) begin errors++; $display("FAIL t4_kept got %b exp 1", conflict_res_valid_o); end
        checks++; if (mem_addr_o !== 32'h4000) begin errors++; $display("FAIL t4_addr0 got %h exp 4000", mem_addr_o); end
        mem_ack_i = 1'b1;
        tick();
        checks++; if (mem_addr_o !== 32'h4004) begin errors++; $display("FAIL t4_addr1 got %h exp 4004", mem_addr_o); end
        tick();
        mem_ack_i = 1'b0;
        checks++; if (store_buf_emp_o !== 1'b1) begin errors++; $display("FAIL t4_emp got %b exp 1", store_buf_emp_o); end
    endtask

    task automatic test_io();
        do_st(2'b10, 32'h80000010, 32'h55AA55AA, 6'd40);
        lookup(2'b10, 32'h80000010);
        checks++; if (conflict_res_valid_o !== 1'b1) begin errors++; $display("FAIL t5_res_valid got %b exp 1", conflict_res_valid_o); end
        checks++; if (conflict_resolvable_o !== 1'b0) begin errors++; $display("FAIL t5_resolvable got %b exp 0", conflict_resolvable_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (store_buf_emp_o !== 1'b1) begin errors++; $display("FAIL t5_emp got %b exp 1", store_buf_emp_o); end
    endtask

    task automatic test_stall_reset();
        do_st(2'b10, 32'h6000, 32'h600D600D, 6'd41);
        do_st(2'b10, 32'h6004, 32'h600D6004, 6'd42);
        do_commit(6'd41);
        do_commit(6'd42);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h6000 || mem_data_o !== 32'h600D600D || mem_bm_o !== 4'hF) begin
                errors++; $display("FAIL t6_stall%0d got req=%b addr=%h data=%h bm=%h exp 1 6000 600d600d f", k, mem_req_o, mem_addr_o, mem_data_o, mem_bm_o);
            end
        end
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        checks++; if (mem_addr_o !== 32'h6004) begin errors++; $display("FAIL t6_next got %h exp 6004", mem_addr_o); end
        rst = 1'b1;
        tick();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t6_rst_req got %b exp 0", mem_req_o); end
        checks++; if (store_buf_emp_o !== 1'b1) begin errors++; $display("FAIL t6_rst_emp got %b exp 1", store_buf_emp_o); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_word_fwd();
        test_byte_merge_drain();
        test_full_wrap();
        test_flush();
        test_io();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
